// File: rtl/nvram_autosave_if.sv
// nvram_autosave_if: strobes, requests and status between the cartridge/OSD
// side (master) and the NVRAM autosave controller (slave).
interface nvram_autosave_if;
  logic [3:0] sram_we;
  logic [3:0] img_mounted;
  logic       osd_save;
  logic       autosave_en;
  logic       load_req;
  logic       save_req;
  logic [3:0] dirty;
  logic       busy;

  modport master (
    output sram_we, img_mounted, osd_save, autosave_en,
    input  load_req, save_req, dirty, busy
  );

  modport slave (
    input  sram_we, img_mounted, osd_save, autosave_en,
    output load_req, save_req, dirty, busy
  );
endinterface

// File: rtl/nvram_autosave.sv
// nvram_autosave: tracks per-slot unsaved SRAM writes and issues one-cycle
// load/save requests to the backup engine, spaced by a holdoff window.
// Optional quiet-timer autosave is built only when NVRAM_AUTOSAVE_TIMER_EN
// is defined; otherwise saves come only from rising edges of osd_save.
//
// state      | meaning
// S_IDLE     | waiting for a pending load, pending save or autosave
// S_LOAD_DLY | letting a fresh mount settle before requesting a load
// S_REQ_LOAD | load_req pulse (one cycle)
// S_REQ_SAVE | save_req pulse (one cycle), dirty flags cleared
// S_HOLDOFF  | minimum gap before the next request
module nvram_autosave #(
  parameter int CLK_KHZ       = 21477,
  parameter int QUIET_MS      = 2000,
  parameter int LOAD_DELAY_MS = 100,
  parameter int HOLDOFF_MS    = 1000
) (
  input  logic               clk,
  input  logic               reset,
  nvram_autosave_if.slave    bus
);
  localparam int PW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_DLY, S_REQ_LOAD, S_REQ_SAVE, S_HOLDOFF
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ms_tick;
  logic          osd_q, osd_rise;
  logic [3:0]    dirty_q, dirty_d;
  logic          load_pend_q, load_pend_d;
  logic          save_pend_q, save_pend_d;
  logic [15:0]   load_cnt_q, load_cnt_d;
  logic [15:0]   hold_cnt_q, hold_cnt_d;
  logic          any_mount;
  logic          auto_save;
  logic          load_req, save_req;

  assign ms_tick   = (presc_q == PW'(CLK_KHZ - 1));
  assign presc_d   = ms_tick ? '0 : presc_q + PW'(1);
  assign osd_rise  = bus.osd_save & ~osd_q;
  assign any_mount = |bus.img_mounted;

  // Pending flags, dirty bits and the load/holdoff timers.
  always_comb begin
    dirty_d     = dirty_q;
    load_pend_d = load_pend_q;
    save_pend_d = save_pend_q;
    load_cnt_d  = load_cnt_q;
    hold_cnt_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.img_mounted[i])         dirty_d[i] = 1'b0;
      else if (bus.sram_we[i])        dirty_d[i] = 1'b1;
      else if (state_q == S_REQ_SAVE) dirty_d[i] = 1'b0;
    end
    // A mount or button edge arriving in the request cycle is kept for later.
    if (state_q == S_REQ_LOAD) load_pend_d = 1'b0;
    if (any_mount)             load_pend_d = 1'b1;
    if (state_q == S_REQ_SAVE) save_pend_d = 1'b0;
    if (osd_rise)              save_pend_d = 1'b1;
    if (state_q == S_LOAD_DLY && ms_tick) load_cnt_d = load_cnt_q + 16'd1;
    if (any_mount)                        load_cnt_d = '0;
    if (state_q == S_HOLDOFF)
      hold_cnt_d = ms_tick ? hold_cnt_q + 16'd1 : hold_cnt_q;
  end

`ifdef NVRAM_AUTOSAVE_TIMER_EN
  logic [15:0] quiet_cnt_q, quiet_cnt_d;

  // Quiet timer: restarts on any write, counts ms only while something is dirty.
  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    if (|bus.sram_we)
      quiet_cnt_d = '0;
    else if (ms_tick && (|dirty_q) && quiet_cnt_q != 16'hFFFF)
      quiet_cnt_d = quiet_cnt_q + 16'd1;
  end

  // Quiet timer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) quiet_cnt_q <= '0;
    else       quiet_cnt_q <= quiet_cnt_d;
  end

  assign auto_save = bus.autosave_en & (|dirty_q) & (quiet_cnt_q >= 16'(QUIET_MS));
`else
  logic unused_autosave_en;
  assign unused_autosave_en = bus.autosave_en;
  assign auto_save          = 1'b0;
`endif

  // Next-state and request outputs; loads take priority over saves.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    save_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_pend_q)      state_d = S_LOAD_DLY;
        else if (save_pend_q) state_d = S_REQ_SAVE;
        else if (auto_save)   state_d = S_REQ_SAVE;
      end
      S_LOAD_DLY: begin
        if (!any_mount && load_cnt_q >= 16'(LOAD_DELAY_MS)) state_d = S_REQ_LOAD;
      end
      S_REQ_LOAD: begin
        load_req = 1'b1;
        state_d  = S_HOLDOFF;
      end
      S_REQ_SAVE: begin
        save_req = 1'b1;
        state_d  = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_cnt_q >= 16'(HOLDOFF_MS)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, prescaler and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      osd_q       <= 1'b0;
      dirty_q     <= '0;
      load_pend_q <= 1'b0;
      save_pend_q <= 1'b0;
      load_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      osd_q       <= bus.osd_save;
      dirty_q     <= dirty_d;
      load_pend_q <= load_pend_d;
      save_pend_q <= save_pend_d;
      load_cnt_q  <= load_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.load_req = load_req;
  assign bus.save_req = save_req;
  assign bus.dirty    = dirty_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_nvram_autosave.sv
// tb_nvram_autosave: directed checks of nvram_autosave with CLK_KHZ=4,
// QUIET_MS=3, LOAD_DELAY_MS=2, HOLDOFF_MS=2. Cycle k counts posedges after
// reset release; ms ticks advance the timers on edges 4, 8, 12, ...
// Autosave expectations follow NVRAM_AUTOSAVE_TIMER_EN.
module tb_nvram_autosave;
`ifdef NVRAM_AUTOSAVE_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  nvram_autosave_if bus_if ();

  nvram_autosave #(
    .CLK_KHZ(4), .QUIET_MS(3), .LOAD_DELAY_MS(2), .HOLDOFF_MS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input bit e_load, input bit e_save,
                         input bit e_busy, input logic [3:0] e_dirty);
    chk($sformatf("%s%0d_load_req", tag, k), {3'b0, bus_if.load_req}, {3'b0, e_load});
    chk($sformatf("%s%0d_save_req", tag, k), {3'b0, bus_if.save_req}, {3'b0, e_save});
    chk($sformatf("%s%0d_busy", tag, k), {3'b0, bus_if.busy}, {3'b0, e_busy});
    chk($sformatf("%s%0d_dirty", tag, k), bus_if.dirty, e_dirty);
  endtask

  // Holds reset for a few cycles; returns #1 after edge E0 with reset still high.
  task automatic start_reset();
    reset = 1'b1;
    bus_if.sram_we     = '0;
    bus_if.img_mounted = '0;
    bus_if.osd_save    = 1'b0;
    bus_if.autosave_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    start_reset();
    chk_all("RST", 0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Mount slot 0: load pulse after the settle delay, then holdoff
    reset = 1'b0;
    bus_if.img_mounted = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("A", k, k == 9, 1'b0, k >= 2 && k <= 16, 4'b0000);
      if (k == 1) bus_if.img_mounted = 4'b0000;
    end

    // Two writes to slot 2, then quiet-timer autosave
    start_reset();
    reset = 1'b0;
    bus_if.autosave_en = 1'b1;
    bus_if.sram_we = 4'b0100;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk_all("B", k, 1'b0, TIMER && k == 21, TIMER && k >= 21 && k <= 28,
              (TIMER && k >= 22) ? 4'b0000 : 4'b0100);
      if (k == 1) bus_if.sram_we = 4'b0000;
      if (k == 8) bus_if.sram_we = 4'b0100;
      if (k == 9) bus_if.sram_we = 4'b0000;
    end

    // Manual save, then a second button edge during holdoff
    start_reset();
    reset = 1'b0;
    bus_if.osd_save = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("C", k, 1'b0, k == 2 || k == 10,
              (k >= 2 && k <= 8) || (k >= 10 && k <= 16), 4'b0000);
      if (k == 3) bus_if.osd_save = 1'b0;
      if (k == 5) bus_if.osd_save = 1'b1;
    end

    // Mount and write to slot 1 together while a save is pending
    start_reset();
    reset = 1'b0;
    bus_if.osd_save    = 1'b1;
    bus_if.img_mounted = 4'b0010;
    bus_if.sram_we     = 4'b0010;
    for (int k = 1; k <= 28; k++) begin
      tick();
      chk_all("D", k, k == 9, k == 18, (k >= 2 && k <= 16) || (k >= 18 && k <= 24), 4'b0000);
      if (k == 1) begin
        bus_if.img_mounted = 4'b0000;
        bus_if.sram_we     = 4'b0000;
      end
    end

    // Write to slot 3 in the save-request cycle survives, then autosaves
    start_reset();
    reset = 1'b0;
    bus_if.autosave_en = 1'b1;
    bus_if.osd_save    = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk_all("E", k, 1'b0, k == 2 || (TIMER && k == 13),
              (k >= 2 && k <= 8) || (TIMER && k >= 13 && k <= 20),
              (k < 3 || (TIMER && k >= 14)) ? 4'b0000 : 4'b1000);
      if (k == 2) bus_if.sram_we = 4'b1000;
      if (k == 3) bus_if.sram_we = 4'b0000;
    end

    // Reset during the load settle delay abandons the load
    start_reset();
    reset = 1'b0;
    bus_if.autosave_en = 1'b1;
    bus_if.img_mounted = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("F", k, 1'b0, 1'b0, k >= 2, (k >= 3) ? 4'b1000 : 4'b0000);
      if (k == 1) bus_if.img_mounted = 4'b0000;
      if (k == 2) bus_if.sram_we = 4'b1000;
      if (k == 3) bus_if.sram_we = 4'b0000;
    end
    reset = 1'b1;
    #1;
    chk_all("F_async", 0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("G", k, 1'b0, 1'b0, 1'b0, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
